// File: rtl/fd_pipe_reg_x.sv
// rtl/fd_pipe_reg_x.sv - fetch-to-decode pipeline register with stall, bubble, exception freeze and event counters
module fd_pipe_reg_x #(
    parameter int         WORD_W    = 64,
    parameter int         CNT_W     = 16,
    parameter logic [3:0] BUB_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [1:0] STAT_AOK  = 2'd0,
    parameter int         HOLD_EXC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        f_stat,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [WORD_W-1:0] f_valC,
    input  logic [WORD_W-1:0] f_valP,
    input  logic              D_stall,
    input  logic              D_bubble,
    output logic [1:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [WORD_W-1:0] D_valC,
    output logic [WORD_W-1:0] D_valP,
    output logic              D_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              conflict,
    output logic              exc_hold
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_BUBBLE,
        ACT_FREEZE,
        ACT_STALL,
        ACT_LOAD
    } act_e;

    logic [1:0]        r_stat;
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [3:0]        r_rA;
    logic [3:0]        r_rB;
    logic [WORD_W-1:0] r_valC;
    logic [WORD_W-1:0] r_valP;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              r_conflict;

    logic              w_freeze;
    act_e              w_act;

    // A freeze is only meaningful for a word that really came from fetch.
    assign w_freeze = (HOLD_EXC != 0) && r_valid && (r_stat != STAT_AOK);

    always_comb begin
        w_act = ACT_LOAD;
        if (!rst_n) begin
            w_act = ACT_RESET;
        end else if (D_bubble) begin
            w_act = ACT_BUBBLE;
        end else if (w_freeze) begin
            w_act = ACT_FREEZE;
        end else if (D_stall) begin
            w_act = ACT_STALL;
        end
    end

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_BUBBLE: begin
                r_stat  <= STAT_AOK;
                r_icode <= BUB_ICODE;
                r_ifun  <= 4'h0;
                r_rA    <= RNONE;
                r_rB    <= RNONE;
                r_valC  <= '0;
                r_valP  <= '0;
                r_valid <= 1'b0;
            end
            ACT_LOAD: begin
                r_stat  <= f_stat;
                r_icode <= f_icode;
                r_ifun  <= f_ifun;
                r_rA    <= f_rA;
                r_rB    <= f_rB;
                r_valC  <= f_valC;
                r_valP  <= f_valP;
                r_valid <= 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_act == ACT_RESET) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_conflict   <= 1'b0;
        end else begin
            if (w_act == ACT_STALL && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_act == ACT_BUBBLE && r_bubble_cnt != CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
            if (D_bubble && D_stall) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign D_stat     = r_stat;
    assign D_icode    = r_icode;
    assign D_ifun     = r_ifun;
    assign D_rA       = r_rA;
    assign D_rB       = r_rB;
    assign D_valC     = r_valC;
    assign D_valP     = r_valP;
    assign D_valid    = r_valid;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign conflict   = r_conflict;
    assign exc_hold   = w_freeze;

endmodule

// File: tb/tb_fd_pipe_reg_x.sv
// tb/tb_fd_pipe_reg_x.sv - bench for fd_pipe_reg_x: default instance and a HOLD_EXC=1, CNT_W=3 instance on shared inputs
module tb_fd_pipe_reg_x;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  f_stat = '0;
    logic [3:0]  f_icode = '0, f_ifun = '0, f_rA = '0, f_rB = '0;
    logic [63:0] f_valC = '0, f_valP = '0;
    logic        D_stall = 1'b0, D_bubble = 1'b0;

    logic [1:0]  a_stat, b_stat;
    logic [3:0]  a_icode, a_ifun, a_rA, a_rB, b_icode, b_ifun, b_rA, b_rB;
    logic [63:0] a_valC, a_valP, b_valC, b_valP;
    logic        a_valid, b_valid, a_conf, b_conf, a_exc, b_exc;
    logic [15:0] a_scnt, a_bcnt;
    logic [2:0]  b_scnt, b_bcnt;

    always #5 clk = ~clk;

    fd_pipe_reg_x dut_a (
        .clk(clk), .rst_n(rst_n), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .D_stat(a_stat), .D_icode(a_icode), .D_ifun(a_ifun), .D_rA(a_rA), .D_rB(a_rB),
        .D_valC(a_valC), .D_valP(a_valP), .D_valid(a_valid),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt), .conflict(a_conf), .exc_hold(a_exc)
    );

    fd_pipe_reg_x #(.CNT_W(3), .HOLD_EXC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .D_stat(b_stat), .D_icode(b_icode), .D_ifun(b_ifun), .D_rA(b_rA), .D_rB(b_rB),
        .D_valC(b_valC), .D_valP(b_valP), .D_valid(b_valid),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt), .conflict(b_conf), .exc_hold(b_exc)
    );

    // Reference model: one decode word plus event bookkeeping per instance.
    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid;
    } dword_t;

    localparam dword_t BUBBLE_WORD = '{stat: 2'd0, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                                       valc: 64'd0, valp: 64'd0, valid: 1'b0};

    dword_t m_d [2];
    int     m_sc [2];
    int     m_bc [2];
    bit     m_conf [2];
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic bit m_frozen(int k);
        return (k == 1) && m_d[k].valid && (m_d[k].stat != 2'd0);
    endfunction

    task automatic model_edge(int k);
        int maxc;
        maxc = (k == 0) ? 65535 : 7;
        if (!rst_n) begin
            m_d[k] = BUBBLE_WORD; m_sc[k] = 0; m_bc[k] = 0; m_conf[k] = 0;
        end else if (D_bubble) begin
            m_d[k] = BUBBLE_WORD;
            if (m_bc[k] < maxc) m_bc[k]++;
            if (D_stall) m_conf[k] = 1;
        end else if (m_frozen(k)) begin
        end else if (D_stall) begin
            if (m_sc[k] < maxc) m_sc[k]++;
        end else begin
            m_d[k] = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                       valc: f_valC, valp: f_valP, valid: 1'b1};
        end
    endtask

    logic [180:0] obs_a, exp_a;
    logic [154:0] obs_b, exp_b;
    assign obs_a = {a_stat, a_icode, a_ifun, a_rA, a_rB, a_valC, a_valP, a_valid, a_conf, a_exc, a_scnt, a_bcnt};
    assign obs_b = {b_stat, b_icode, b_ifun, b_rA, b_rB, b_valC, b_valP, b_valid, b_conf, b_exc, b_scnt, b_bcnt};
    assign exp_a = {m_d[0], m_conf[0], 1'b0, 16'(m_sc[0]), 16'(m_bc[0])};
    assign exp_b = {m_d[1], m_conf[1], m_frozen(1), 3'(m_sc[1]), 3'(m_bc[1])};

    task automatic rand_f(int exc_pct);
        f_stat  = ($urandom_range(0, 99) < exc_pct) ? 2'($urandom_range(1, 3)) : 2'd0;
        f_icode = 4'($urandom); f_ifun = 4'($urandom);
        f_rA    = 4'($urandom); f_rB   = 4'($urandom);
        f_valC  = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
    endtask

    task automatic tick(input logic rn, input logic st, input logic bb);
        @(negedge clk);
        rst_n = rn; D_stall = st; D_bubble = bb;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic test_reset;
        rand_f(0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL reset_a got %h want %h", obs_a, exp_a); end
        n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL reset_b got %h want %h", obs_b, exp_b); end
        n_cmp++; if ({a_valid, a_icode, a_rA, a_conf} !== {1'b0, 4'h1, 4'hF, 1'b0}) begin
            n_bad++; $display("FAIL reset_fields got %h want %h", {a_valid, a_icode, a_rA, a_conf}, {1'b0, 4'h1, 4'hF, 1'b0});
        end
    endtask

    task automatic test_load;
        f_stat = 2'd0; f_icode = 4'd6; f_ifun = 4'd0; f_rA = 4'd2; f_rB = 4'd3;
        f_valC = 64'h10; f_valP = 64'h100;
        tick(1'b1, 1'b0, 1'b0);
        n_cmp++; if ({a_icode, a_valP, a_valid} !== {4'd6, 64'h100, 1'b1}) begin
            n_bad++; $display("FAIL first_load got %h want %h", {a_icode, a_valP, a_valid}, {4'd6, 64'h100, 1'b1});
        end
        for (int i = 0; i < 4; i++) begin
            rand_f(0);
            tick(1'b1, 1'b0, 1'b0);
            n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL load_a got %h want %h", obs_a, exp_a); end
            n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL load_b got %h want %h", obs_b, exp_b); end
        end
    endtask

    task automatic test_stall;
        logic [3:0] held;
        tick(1'b0, 1'b0, 1'b0);
        rand_f(0);
        tick(1'b1, 1'b0, 1'b0);
        held = f_icode;
        for (int i = 0; i < 3; i++) begin
            rand_f(0);
            tick(1'b1, 1'b1, 1'b0);
            n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL stall_a got %h want %h", obs_a, exp_a); end
        end
        n_cmp++; if ({a_icode, a_scnt} !== {held, 16'd3}) begin
            n_bad++; $display("FAIL stall_cnt3 got %h want %h", {a_icode, a_scnt}, {held, 16'd3});
        end
    endtask

    task automatic test_bubble;
        rand_f(0);
        tick(1'b1, 1'b0, 1'b1);
        n_cmp++; if ({a_icode, a_rA, a_rB, a_valC, a_valid, a_bcnt} !== {4'h1, 4'hF, 4'hF, 64'd0, 1'b0, 16'd1}) begin
            n_bad++; $display("FAIL bubble got %h want %h", {a_icode, a_rA, a_rB, a_valC, a_valid, a_bcnt},
                              {4'h1, 4'hF, 4'hF, 64'd0, 1'b0, 16'd1});
        end
        n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL bubble_b got %h want %h", obs_b, exp_b); end
    endtask

    task automatic test_conflict;
        tick(1'b1, 1'b1, 1'b1);
        n_cmp++; if ({a_conf, a_valid, a_bcnt} !== {1'b1, 1'b0, 16'd2}) begin
            n_bad++; $display("FAIL conflict_set got %h want %h", {a_conf, a_valid, a_bcnt}, {1'b1, 1'b0, 16'd2});
        end
        for (int i = 0; i < 10; i++) begin
            rand_f(0);
            tick(1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (a_conf !== 1'b1) begin n_bad++; $display("FAIL conflict_sticky got %b want 1", a_conf); end
        n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL conflict_a got %h want %h", obs_a, exp_a); end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++; if ({a_conf, a_scnt} !== {1'b0, 16'd0}) begin
            n_bad++; $display("FAIL conflict_clear got %h want %h", {a_conf, a_scnt}, {1'b0, 16'd0});
        end
    endtask

    task automatic test_freeze;
        logic [3:0] held;
        tick(1'b0, 1'b0, 1'b0);
        rand_f(0);
        f_stat = 2'd2;
        held = f_icode;
        tick(1'b1, 1'b0, 1'b0);
        n_cmp++; if ({b_exc, a_exc} !== 2'b10) begin n_bad++; $display("FAIL freeze_enter got %b want 10", {b_exc, a_exc}); end
        for (int i = 0; i < 3; i++) begin
            rand_f(0);
            tick(1'b1, 1'(i == 1), 1'b0);
            n_cmp++; if ({b_exc, b_icode, b_scnt} !== {1'b1, held, 3'd0}) begin
                n_bad++; $display("FAIL freeze_hold got %h want %h", {b_exc, b_icode, b_scnt}, {1'b1, held, 3'd0});
            end
        end
        n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL freeze_a got %h want %h", obs_a, exp_a); end
        tick(1'b1, 1'b0, 1'b1);
        n_cmp++; if ({b_exc, b_valid, b_icode} !== {1'b0, 1'b0, 4'h1}) begin
            n_bad++; $display("FAIL freeze_release got %h want %h", {b_exc, b_valid, b_icode}, {1'b0, 1'b0, 4'h1});
        end
    endtask

    task automatic test_saturation;
        tick(1'b0, 1'b0, 1'b0);
        rand_f(0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rand_f(50);
            tick(1'b1, 1'b1, 1'b0);
            n_cmp++; if (b_scnt !== 3'(i < 7 ? i + 1 : 7)) begin
                n_bad++; $display("FAIL sat_step got %0d want %0d", b_scnt, (i < 7 ? i + 1 : 7));
            end
        end
        n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL sat_b got %h want %h", obs_b, exp_b); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            rand_f(20);
            tick(1'($urandom_range(0, 99) >= 3), 1'($urandom_range(0, 99) < 35),
                 1'($urandom_range(0, 99) < 12));
            n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL rand_a cyc %0d got %h want %h", i, obs_a, exp_a); end
            n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL rand_b cyc %0d got %h want %h", i, obs_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_bubble();
        test_conflict();
        test_freeze();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
